// File: rtl/rr_packet_arbiter.sv
// Packet-locking round-robin arbiter for one router output port with four requesters
// (port 0 = local injection, ports 1-3 = neighbours) and a watchdog that frees a stalled grant.
module rr_packet_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] port_req,
  input  logic [3:0] port_tail,
  input  logic       out_ready,
  output logic [3:0] grant,
  output logic [1:0] mux_select,
  output logic       out_valid,
  output logic [3:0] port_block,
  output logic       timeout_err,
  output logic       dbg_busy,
  output logic [1:0] dbg_ptr,
  output logic [7:0] dbg_wd
);

  // Handshake: a flit moves on a cycle where out_valid and out_ready are both high;
  // a requester holds port_req (and port_tail) stable until that happens.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] g_q, g_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] wd_q, wd_d;
  logic [3:0] grant_q, grant_d;
  logic       terr_q, terr_d;

  logic       xfer;
  logic [2:0] idle_win;
  logic [2:0] tail_win;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Returns {found, index}; offsets are walked high to low so the lowest offset from start wins.
  function automatic logic [2:0] arb(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign xfer     = (state_q == BUSY) && port_req[g_q] && out_ready;
  assign idle_win = arb(port_req, ptr_q);
  // The finishing port is masked so a competitor can take over with no bubble.
  assign tail_win = arb(port_req & ~onehot(g_q), g_q + 2'd1);

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    grant_d = grant_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (idle_win[2]) begin
          state_d = BUSY;
          g_d     = idle_win[1:0];
          grant_d = onehot(idle_win[1:0]);
          wd_d    = 8'd0;
        end else begin
          grant_d = 4'b0000;
        end
      end
      BUSY: begin
        if (xfer) begin
          wd_d = 8'd0;
          if (port_tail[g_q]) begin
            ptr_d = g_q + 2'd1;
            if (tail_win[2]) begin
              g_d     = tail_win[1:0];
              grant_d = onehot(tail_win[1:0]);
            end else begin
              state_d = IDLE;
              grant_d = 4'b0000;
            end
          end
        end else if (wd_q == WD_LAST) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          ptr_d   = g_q + 2'd1;
          wd_d    = 8'd0;
          terr_d  = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= 2'd0;
      ptr_q   <= 2'd0;
      wd_q    <= 8'd0;
      grant_q <= 4'b0000;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      grant_q <= grant_d;
      terr_q  <= terr_d;
    end
  end

  assign grant       = grant_q;
  assign mux_select  = g_q;
  assign timeout_err = terr_q;
  assign out_valid   = (state_q == BUSY) && port_req[g_q];
  assign port_block  = port_req & ~(grant_q & {4{out_ready}});

  assign dbg_busy = (state_q == BUSY);
  assign dbg_ptr  = ptr_q;
  assign dbg_wd   = wd_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Self-checking bench for rr_packet_arbiter: one instance at TIMEOUT=64 and one at TIMEOUT=8
// share all stimulus; scenario tasks compare against hand-derived expectations.
module tb_rr_packet_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] port_req;
  logic [3:0] port_tail;
  logic       out_ready;

  logic [3:0] grant, port_block;
  logic [1:0] mux_select, dbg_ptr;
  logic       out_valid, timeout_err, dbg_busy;
  logic [7:0] dbg_wd;

  logic [3:0] grant8, port_block8;
  logic [1:0] mux_select8, dbg_ptr8;
  logic       out_valid8, timeout_err8, dbg_busy8;
  logic [7:0] dbg_wd8;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  rr_packet_arbiter #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .port_req(port_req), .port_tail(port_tail), .out_ready(out_ready),
    .grant(grant), .mux_select(mux_select), .out_valid(out_valid), .port_block(port_block),
    .timeout_err(timeout_err), .dbg_busy(dbg_busy), .dbg_ptr(dbg_ptr), .dbg_wd(dbg_wd)
  );

  rr_packet_arbiter #(.TIMEOUT(8)) dut8 (
    .clk(clk), .reset(reset), .port_req(port_req), .port_tail(port_tail), .out_ready(out_ready),
    .grant(grant8), .mux_select(mux_select8), .out_valid(out_valid8), .port_block(port_block8),
    .timeout_err(timeout_err8), .dbg_busy(dbg_busy8), .dbg_ptr(dbg_ptr8), .dbg_wd(dbg_wd8)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] tail, input logic rdy);
    port_req  = req;
    port_tail = tail;
    out_ready = rdy;
  endtask

  task automatic do_reset(input logic [3:0] req_during);
    reset = 1'b1;
    drive(req_during, 4'b0000, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    drive(4'b0000, 4'b0000, 1'b1);
  endtask

  // scenarios
  task automatic test_reset();
    logic [3:0] r;
    r = 4'($urandom_range(1, 15));
    do_reset(r);
    reset = 1'b1;
    drive(r, 4'b0000, 1'b1);
    #1;
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_checks++; if (mux_select !== 2'b00) begin n_fail++; $display("FAIL reset_mux: got %b expected 00", mux_select); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %b expected 0", timeout_err); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (port_block !== r) begin n_fail++; $display("FAIL reset_block: got %b expected %b", port_block, r); end
    tick();
    reset = 1'b0;
    drive(4'b0000, 4'b0000, 1'b1);
  endtask

  task automatic test_single();
    int xfers;
    do_reset(4'b0000);
    drive(4'b0100, 4'b0000, 1'b1);
    tick();
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b expected 0100", grant); end
    n_checks++; if (mux_select !== 2'b10) begin n_fail++; $display("FAIL single_mux: got %b expected 10", mux_select); end
    xfers = 0;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, (i == 2) ? 4'b0100 : 4'b0000, 1'b1);
      #1;
      if (out_valid && out_ready) xfers++;
      tick();
    end
    drive(4'b0000, 4'b0000, 1'b1);
    n_checks++; if (xfers != 3) begin n_fail++; $display("FAIL single_xfers: got %0d expected 3", xfers); end
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_release: got %b expected 0000", grant); end
    n_checks++; if (dbg_ptr !== 2'd3) begin n_fail++; $display("FAIL single_ptr: got %0d expected 3", dbg_ptr); end
  endtask

  task automatic test_fairness();
    logic [3:0] e;
    do_reset(4'b0000);
    exp_q = {};
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    drive(4'b1111, 4'b1111, 1'b1);
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      n_checks++; if (grant !== e) begin n_fail++; $display("FAIL fair_grant: got %b expected %b", grant, e); end
      n_checks++; if (port_block !== ~e) begin n_fail++; $display("FAIL fair_block: got %b expected %b", port_block, ~e); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fair_out_valid: got %b expected 1", out_valid); end
    end
  endtask

  task automatic test_packet_lock();
    logic [3:0] e;
    do_reset(4'b0000);
    exp_q = {};
    for (int k = 0; k < 4; k++) exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    drive(4'b0010, 4'b0000, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_checks++; if (grant !== e) begin n_fail++; $display("FAIL lock_grant%0d: got %b expected %b", k, grant, e); end
      drive((k == 0) ? 4'b0010 : 4'b0011, (k == 3) ? 4'b0010 : 4'b0000, 1'b1);
      #1;
      if (k == 1) begin
        n_checks++; if (port_block !== 4'b0001) begin n_fail++; $display("FAIL lock_block: got %b expected 0001", port_block); end
      end
      tick();
    end
    e = exp_q.pop_front();
    n_checks++; if (grant !== e) begin n_fail++; $display("FAIL lock_switch: got %b expected %b", grant, e); end
    n_checks++; if (mux_select !== 2'b00) begin n_fail++; $display("FAIL lock_mux: got %b expected 00", mux_select); end
  endtask

  task automatic test_backpressure();
    do_reset(4'b0000);
    drive(4'b0001, 4'b0000, 1'b1);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, 4'b0000, 1'b0);
      #1;
      n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL bp_grant%0d: got %b expected 0001", k, grant); end
      n_checks++; if (port_block !== 4'b0001) begin n_fail++; $display("FAIL bp_block%0d: got %b expected 0001", k, port_block); end
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL bp_terr%0d: got %b expected 0", k, timeout_err); end
      tick();
    end
    drive(4'b0001, 4'b0001, 1'b1);
    #1;
    n_checks++; if (dbg_wd !== 8'd5) begin n_fail++; $display("FAIL bp_wd: got %0d expected 5", dbg_wd); end
    n_checks++; if (port_block !== 4'b0000) begin n_fail++; $display("FAIL bp_resume_block: got %b expected 0000", port_block); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resume_valid: got %b expected 1", out_valid); end
    tick();
    drive(4'b0000, 4'b0000, 1'b1);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL bp_release: got %b expected 0000", grant); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL bp_terr_end: got %b expected 0", timeout_err); end
  endtask

  task automatic test_timeout();
    logic [3:0] e;
    do_reset(4'b0000);
    drive(4'b0100, 4'b0000, 1'b1);
    tick();
    n_checks++; if (grant8 !== 4'b0100) begin n_fail++; $display("FAIL to_grant: got %b expected 0100", grant8); end
    drive(4'b0000, 4'b0000, 1'b1);
    exp_q = {};
    for (int k = 0; k < 7; k++) exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0000);
    for (int k = 0; k < 8; k++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++; if (grant8 !== e) begin n_fail++; $display("FAIL to_grant%0d: got %b expected %b", k, grant8, e); end
      n_checks++; if (timeout_err8 !== (k == 7)) begin n_fail++; $display("FAIL to_terr%0d: got %b expected %b", k, timeout_err8, (k == 7)); end
    end
    n_checks++; if (dbg_ptr8 !== 2'd3) begin n_fail++; $display("FAIL to_ptr: got %0d expected 3", dbg_ptr8); end
    tick();
    n_checks++; if (timeout_err8 !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b expected 0", timeout_err8); end
  endtask

  task automatic test_same_port();
    logic [3:0] e;
    do_reset(4'b0000);
    exp_q = {};
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0000);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0000);
    drive(4'b1000, 4'b1000, 1'b1);
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      n_checks++; if (grant !== e) begin n_fail++; $display("FAIL same_port_grant: got %b expected %b", grant, e); end
    end
    n_checks++; if (mux_select !== 2'b11) begin n_fail++; $display("FAIL same_port_mux: got %b expected 11", mux_select); end
  endtask

  task automatic test_reset_mid();
    do_reset(4'b0000);
    drive(4'b0010, 4'b0000, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rmid_grant: got %b expected 0000", grant); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rmid_terr: got %b expected 0", timeout_err); end
    n_checks++; if (mux_select !== 2'b00) begin n_fail++; $display("FAIL rmid_mux: got %b expected 00", mux_select); end
    reset = 1'b0;
    drive(4'b0000, 4'b0000, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] r, eb;
    logic       y;
    do_reset(4'b0000);
    for (int i = 0; i < 150; i++) begin
      r = 4'($urandom_range(0, 15));
      y = 1'($urandom_range(0, 1));
      drive(r, 4'($urandom_range(0, 15)), y);
      #1;
      eb = r & ~(grant & {4{y}});
      n_checks++; if (port_block !== eb) begin n_fail++; $display("FAIL rnd_block: got %b expected %b", port_block, eb); end
      n_checks++; if (!$onehot0(grant)) begin n_fail++; $display("FAIL rnd_onehot: got %b expected onehot0", grant); end
      n_checks++; if (out_valid !== |(grant & r)) begin n_fail++; $display("FAIL rnd_valid: got %b expected %b", out_valid, |(grant & r)); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 1'b1);
    test_reset();
    test_single();
    test_fairness();
    test_packet_lock();
    test_backpressure();
    test_timeout();
    test_same_port();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
